// File: rtl/add_issue_ctrl_if.sv
// Handshake bundle for add_issue_ctrl: upstream operands, adder issue/return,
// downstream results and the sticky error flag.
interface add_issue_ctrl_if #(
  parameter int W = 20
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] add_y;
  logic         add_valid;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         err;

  modport slave (
    input  in_valid, in_a, in_b, add_y, add_valid, out_ready,
    output in_ready, start, a, b, out_valid, out_sum, err
  );

  modport master (
    output in_valid, in_a, in_b, add_y, add_valid, out_ready,
    input  in_ready, start, a, b, out_valid, out_sum, err
  );
endinterface

// File: rtl/add_issue_ctrl.sv
// Initiator for the two-stage operand adder: skewed a/b issue, credit-limited
// result FIFO with a registered head, and sticky detection of adder anomalies.
module add_issue_ctrl #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  add_issue_ctrl_if.slave  io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          w_in_ready;
  logic          w_acc;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [CW-1:0] w_remain;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [W-1:0]  w_head_nxt;

  logic          r_start;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_b_hold;
  logic [2:0]    r_exp_sr;
  logic          r_err;
  logic [CW-1:0] r_credits;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          r_out_valid;
  logic [W-1:0]  r_out_sum;

  assign w_in_ready = (r_credits < CW'(DEPTH));
  assign w_acc      = io_bus.in_valid && w_in_ready;
  assign w_pop      = r_out_valid && io_bus.out_ready;
  assign w_full     = (r_count == CW'(DEPTH));
  // A write into a full FIFO is only possible when the head leaves the same cycle.
  assign w_wr       = io_bus.add_valid && (!w_full || w_pop);

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.start     = r_start;
  assign io_bus.a         = r_a;
  assign io_bus.b         = r_b;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.err       = r_err;

  // Next FIFO occupancy, read pointer and head value for the registered output.
  always_comb begin
    w_remain    = r_count;
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd_ptr;
    w_head_nxt  = {W{1'b0}};
    if (w_pop) begin
      w_remain = r_count - CW'(1);
      w_rd_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_remain = r_count;
      w_rd_nxt = r_rd_ptr;
    end
    if (w_wr) begin
      w_count_nxt = w_remain + CW'(1);
    end else begin
      w_count_nxt = w_remain;
    end
    // An empty FIFO being written presents the incoming sum directly as head.
    if (w_count_nxt == {CW{1'b0}}) begin
      w_head_nxt = {W{1'b0}};
    end else if (w_remain == {CW{1'b0}}) begin
      w_head_nxt = io_bus.add_y;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Issue stages, expectation tracking, credits and FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start     <= 1'b0;
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_b_hold    <= {W{1'b0}};
      r_exp_sr    <= 3'b000;
      r_err       <= 1'b0;
      r_credits   <= {CW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_sum   <= {W{1'b0}};
    end else begin
      r_start  <= w_acc;
      r_a      <= w_acc ? io_bus.in_a : {W{1'b0}};
      r_b_hold <= w_acc ? io_bus.in_b : r_b_hold;
      r_b      <= r_start ? r_b_hold : {W{1'b0}};
      r_exp_sr <= {r_exp_sr[1:0], w_acc};
      r_err    <= r_err || (io_bus.add_valid != r_exp_sr[2]);
      // Credits floor at zero so a popped spurious result cannot wrap the counter.
      case ({w_acc, w_pop})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= (r_credits != {CW{1'b0}}) ? r_credits - CW'(1) : r_credits;
        default: r_credits <= r_credits;
      endcase
      r_count     <= w_count_nxt;
      r_wr_ptr    <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr    <= w_rd_nxt;
      r_out_valid <= (w_count_nxt != {CW{1'b0}});
      r_out_sum   <= w_head_nxt;
    end
  end

  // Result storage; contents are don't-care until written after reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= io_bus.add_y;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end
endmodule

// File: doc/add_issue_ctrl.md
Name: add_issue_ctrl

Overview:
- Initiator-side controller for the team's two-stage operand adder (start/a/b in, y/valid out).
- Accepts operand pairs from upstream over valid/ready and drives start, a and b with the adder's skewed timing: a is sampled with start, b one cycle later.
- Captures returned sums into a result FIFO presented downstream over valid/ready.
- Credit-based flow control guarantees the FIFO never overflows; a sticky error flag reports protocol anomalies from the adder.

Parameters:
- W, 20, operand and sum width.
- DEPTH, 4, result FIFO depth; also the max outstanding operations (power of 2, >= 4).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  W  first operand.
- in_b  input  W  second operand.
- start  output  1  adder start pulse.
- a  output  W  adder operand a, valid in the start cycle.
- b  output  W  adder operand b, valid the cycle after start.
- add_y  input  W  adder sum.
- add_valid  input  1  adder result valid.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  result sum.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync use after deassert): start=0, a=0, b=0, out_valid=0, out_sum=0, err=0; credits=0; FIFO empty; expectation shift register cleared. Reset mid-operation discards all in-flight ops and FIFO contents.
- Accept: acc = in_valid && in_ready. in_ready = (credits < DEPTH), registered-free combinational from the credit counter.
- Issue, accept at cycle t:
  - t+1: start=1, a=in_a(t).
  - t+2: b=in_b(t).
  - At other cycles start=0 and a=0. b=0 unless the previous cycle had start=1.
  - Back-to-back accepts are legal every cycle: the a stage and b stage are independent registers.
- Credits:
  - +1 on acc; -1 on out_valid && out_ready.
  - Both in the same cycle: credits unchanged.
  - Range 0..DEPTH.
- Expectation tracking:
  - 3-bit shift register records start.
  - An add_valid is expected at t+3 for an accept at t.
  - add_valid not equal to the expected bit in any cycle sets err (held until reset).
  - An unexpected add_valid is still written if the FIFO has space; otherwise it is dropped.
- Capture: add_valid writes add_y into the FIFO tail the same cycle.
- Output:
  - out_valid = FIFO non-empty; out_sum = head entry, registered storage.
  - The first result is visible at t+4, so accept-to-out_valid latency is 4 cycles.
  - Pop on out_valid && out_ready.
  - Write and pop in the same cycle are legal at any occupancy, including full (occupancy unchanged).
- Ordering: results leave strictly in accept order.
- Arithmetic: out_sum is exactly add_y, W bits; the carry is not reconstructed.
- Full: with credits==DEPTH, in_ready=0 until a pop. In the pop cycle in_ready stays 0; it rises the next cycle.
- out_ready held low indefinitely: at most DEPTH ops are accepted, then the block stalls without loss.
- Pointers: log2(DEPTH)-bit wrap-around, plus an occupancy count of log2(DEPTH)+1 bits.

Test Plan:
1. Single op, out_ready=1:
   - Stimulus: in_a=0x00005, in_b=0x00003 accepted at cycle 0.
   - Expect: start=1 and a=5 at cycle 1; b=3 at cycle 2; adder returns 8 at cycle 3; out_valid=1, out_sum=0x00008 at cycle 4; err=0.
2. Back-to-back:
   - Stimulus: 3 pairs (1,2), (0xFFFFF,1), (10,20) on consecutive cycles.
   - Expect: start high for 3 cycles; b lags a by one cycle; outputs 3, 0x00000 (wrap), 30 in order at cycles 4, 5, 6.
3. Backpressure, DEPTH=4, out_ready=0:
   - Stimulus: offer 6 pairs.
   - Expect: exactly 4 accepted; in_ready=0 from the cycle after the 4th accept.
   - Then raise out_ready: 4 results drain in order; in_ready re-asserts one cycle after the first pop.
4. Simultaneous events:
   - Stimulus: FIFO full, with a pop and an add_valid write in the same cycle.
   - Expect: occupancy stays 4, no entry lost; credits unchanged on the accept+pop cycle.
5. Protocol error:
   - Stimulus: inject add_valid with no prior start, value 0x12345.
   - Expect: err=1 the next cycle and stays 1; the spurious value appears at out_sum if there was space.
   - Also: suppress an expected add_valid -> err=1.
6. Reset mid-operation:
   - Stimulus: assert rst_n=0 with 2 ops in flight and 1 in the FIFO.
   - Expect: all outputs 0 immediately; after release, in_ready=1 and no stale results or err.
